float_to_int_seq: RTL

Multi-cycle IEEE-754 single-precision to signed 32-bit integer converter for the calc_float ALU datapath. It is the return path of the ALU's integer-to-float conversion. An iterative right-shifter aligns the mantissa, then a registered two's-complement stage applies the sign. It has a start/ready/done handshake and sits beside the other calc_float operators behind the ALU result mux.

---
 rtl/float_to_int_seq_pkg.sv | 19 +
 rtl/float_to_int_seq_neg_32.sv | 11 +
 rtl/float_to_int_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/float_to_int_seq_pkg.sv
// float_pkg: shared constants and FSM state type for the float-to-int converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package float_pkg;

  localparam int BIAS  = 127;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

endpackage

// File: rtl/float_to_int_seq_neg_32.sv
// neg_32: 32-bit two's-complement negate.
// Latency: combinational.
// Backpressure: none.
module neg_32 (
  input  logic [31:0] i_a,
  output logic [31:0] o_y
);

  assign o_y = ~i_a + 32'd1;

endmodule

// File: rtl/float_to_int_seq.sv
// float_to_int_seq: iterative IEEE-754 single to signed int32 converter (macro FLOAT_TO_INT_RNE_EN enables RNE).
// Latency: ceil(k/SHIFT_PER_CYCLE)+1 cycles on the shift path, 1 cycle for NaN/Inf/overflow/small inputs.
// Backpressure: ready is high only in IDLE; start while busy is dropped, nothing is queued.
import float_pkg::*;

module float_to_int_seq #(
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in,
  output logic        ready,
  output logic        done,
  output logic [31:0] out,
  output logic        overflow,
  output logic        invalid
);

  localparam logic [5:0] SPC   = 6'(SHIFT_PER_CYCLE);
  localparam logic [7:0] OVF_E = 8'(BIAS + 31);
`ifdef FLOAT_TO_INT_RNE_EN
  // 0.5 <= |x| < 1 can round up to 1, so e=126 also walks the shifter.
  localparam logic [7:0] MIN_SHIFT_E = 8'(BIAS - 1);
`else
  localparam logic [7:0] MIN_SHIFT_E = 8'(BIAS);
`endif

  // Input fields
  logic             w_s;
  logic [EXP_W-1:0] w_e;
  logic [MAN_W-1:0] w_m;

  assign w_s = in[31];
  assign w_e = in[MAN_W +: EXP_W];
  assign w_m = in[MAN_W-1:0];

  // Operation state
  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_fin;
  logic [5:0]  r_k;
  logic [31:0] r_mag;
  logic        r_sign;
  logic        r_ovf;
  logic        r_inv;

  // Output registers
  logic        r_done;
  logic [31:0] r_out;
  logic        r_overflow;
  logic        r_invalid;

  // Classification of the incoming operand
  logic [31:0] w_ld_mag;
  logic [5:0]  w_ld_k;
  logic        w_ld_ovf;
  logic        w_ld_inv;
  logic        w_go_shift;

  // Shift step
  logic [5:0]  w_amt;
  logic [5:0]  w_k_nxt;
  logic [31:0] w_mag_sh;

  // Finish path
  logic [31:0] w_mag_fin;
  logic [31:0] w_mag_neg;
  logic        w_rnd_ovf;
  logic [31:0] w_res;
  logic        w_ovf_fin;

`ifdef FLOAT_TO_INT_RNE_EN
  logic        r_guard;
  logic        r_sticky;
  logic [32:0] w_vec;
  logic [32:0] w_vec_sh;
  logic [32:0] w_mask;
  logic        w_guard_sh;
  logic        w_sticky_sh;
  logic        w_round_up;
`endif

  // Sort the operand into NaN / Inf / overflow / small / shift-path and prepare the load values.
  always_comb begin
    w_ld_mag   = '0;
    w_ld_k     = '0;
    w_ld_ovf   = 1'b0;
    w_ld_inv   = 1'b0;
    w_go_shift = 1'b0;
    if (w_e == 8'hFF) begin
      if (w_m != '0) begin
        w_ld_inv = 1'b1;
      end else begin
        w_ld_ovf = 1'b1;
      end
    end else if (w_e >= OVF_E) begin
      // -2^31 is the one representable value with e=158.
      if (in == 32'hCF00_0000) begin
        w_ld_mag = INT_MIN;
      end else begin
        w_ld_ovf = 1'b1;
      end
    end else if (w_e >= MIN_SHIFT_E) begin
      w_ld_mag   = {1'b1, w_m, 8'b0};
      w_ld_k     = 6'(OVF_E - w_e);
      w_go_shift = 1'b1;
    end
  end

  // One shifter step: move right by min(k, SHIFT_PER_CYCLE).
  always_comb begin
    w_amt   = (r_k < SPC) ? r_k : SPC;
    w_k_nxt = r_k - w_amt;
`ifdef FLOAT_TO_INT_RNE_EN
    // Guard rides below the magnitude; everything pushed past it folds into sticky.
    w_vec       = {r_mag, r_guard};
    w_vec_sh    = w_vec >> w_amt;
    w_mask      = (33'd1 << w_amt) - 33'd1;
    w_mag_sh    = w_vec_sh[32:1];
    w_guard_sh  = w_vec_sh[0];
    w_sticky_sh = r_sticky | (|(w_vec & w_mask));
`else
    w_mag_sh    = r_mag >> w_amt;
`endif
  end

  // Final magnitude, rounding and saturation for the FIN cycle.
  always_comb begin
`ifdef FLOAT_TO_INT_RNE_EN
    w_round_up = r_guard & (r_sticky | r_mag[0]);
    w_mag_fin  = r_mag + {31'b0, w_round_up};
    // Only a rounding carry can reach bit 31 on a positive operand.
    w_rnd_ovf  = ~r_sign & w_mag_fin[31];
`else
    w_mag_fin  = r_mag;
    w_rnd_ovf  = 1'b0;
`endif
    w_ovf_fin = r_ovf | w_rnd_ovf;
    if (r_inv) begin
      w_res = '0;
    end else if (w_ovf_fin) begin
      w_res = r_sign ? INT_MIN : INT_MAX;
    end else begin
      w_res = r_sign ? w_mag_neg : w_mag_fin;
    end
  end

  neg_32 u_neg (
    .i_a (w_mag_fin),
    .o_y (w_mag_neg)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and control strobes.
  always_comb begin
    w_next   = r_state;
    ready    = 1'b0;
    w_accept = 1'b0;
    w_fin    = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = w_go_shift ? SHIFT : FIN;
        end
      end
      SHIFT: begin
        if (w_k_nxt == 6'd0) begin
          w_next = FIN;
        end
      end
      FIN: begin
        w_fin  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: load on accept, shift while in SHIFT, publish results leaving FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k        <= '0;
      r_mag      <= '0;
      r_sign     <= 1'b0;
      r_ovf      <= 1'b0;
      r_inv      <= 1'b0;
      r_done     <= 1'b0;
      r_out      <= '0;
      r_overflow <= 1'b0;
      r_invalid  <= 1'b0;
`ifdef FLOAT_TO_INT_RNE_EN
      r_guard    <= 1'b0;
      r_sticky   <= 1'b0;
`endif
    end else begin
      r_done <= w_fin;
      if (w_accept) begin
        r_sign   <= w_s;
        r_mag    <= w_ld_mag;
        r_k      <= w_ld_k;
        r_ovf    <= w_ld_ovf;
        r_inv    <= w_ld_inv;
`ifdef FLOAT_TO_INT_RNE_EN
        r_guard  <= 1'b0;
        r_sticky <= 1'b0;
`endif
      end else if (r_state == SHIFT) begin
        r_mag    <= w_mag_sh;
        r_k      <= w_k_nxt;
`ifdef FLOAT_TO_INT_RNE_EN
        r_guard  <= w_guard_sh;
        r_sticky <= w_sticky_sh;
`endif
      end
      if (w_fin) begin
        r_out      <= w_res;
        r_overflow <= w_ovf_fin;
        r_invalid  <= r_inv;
      end
    end
  end

  assign done     = r_done;
  assign out      = r_out;
  assign overflow = r_overflow;
  assign invalid  = r_invalid;

endmodule
